// File: rtl/rf_pkg.sv
// Shared register-file write types: widths and the write-request record
// used by the register file and the writeback stages.
package rf_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = $clog2(NREG);

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry FIFO of writeback requests, with per-entry valid/rd taps so the
// parent can build a pending-destination mask.
module wb_fifo2
    import rf_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  wb_req_t                push_req,
    input  logic                   pop,
    output wb_req_t                head,
    output logic                   full,
    output logic                   empty,
    output logic [1:0]             ent_valid,
    output logic [1:0][REG_AW-1:0] ent_rd
);

    wb_req_t    mem [2];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] count;
    logic       do_push;
    logic       do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset; validity comes from count alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_req;
    end

    always_comb begin
        ent_valid = '0;
        ent_rd    = '0;
        for (int i = 0; i < 2; i++) begin
            ent_valid[i] = (count == 2'd2) || ((count == 2'd1) && (rd_ptr == 1'(i)));
            ent_rd[i]    = mem[i].rd;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the single register-file write port: source A is
// unbuffered, source B is queued, and B is forced through after a bounded wait.
module rf_wb_arbiter #(
    parameter int XLEN         = rf_pkg::XLEN,
    parameter int NREG         = rf_pkg::NREG,
    parameter int STARVE_LIMIT = 4,
    localparam int REG_AW      = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [REG_AW-1:0] a_rd,
    input  logic [XLEN-1:0]   a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [REG_AW-1:0] b_rd,
    input  logic [XLEN-1:0]   b_data,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_wreg,
    output logic [XLEN-1:0]   rf_wdata,
    output logic [NREG-1:0]   pend_mask
);

    import rf_pkg::*;

    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    wb_req_t                push_req;
    wb_req_t                head;
    logic                   full;
    logic                   empty;
    logic [1:0]             ent_valid;
    logic [1:0][REG_AW-1:0] ent_rd;
    logic                   b_push;
    logic                   force_b;
    logic                   grant_a;
    logic                   grant_b;
    logic [CNT_W-1:0]       starve_cnt;

    assign push_req = '{rd: b_rd, data: b_data};

    wb_fifo2 u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (b_push),
        .push_req  (push_req),
        .pop       (grant_b),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .ent_valid (ent_valid),
        .ent_rd    (ent_rd)
    );

    // Readies are held low during reset so nothing handshakes into a block being cleared.
    assign force_b = !empty && (starve_cnt == CNT_MAX);
    assign a_ready = reset && !force_b;
    assign b_ready = reset && !full;
    assign b_push  = b_valid && b_ready;
    assign grant_a = a_valid && a_ready;
    assign grant_b = reset && !grant_a && !empty;

    always_comb begin
        pend_mask = '0;
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                if (ent_valid[i]) pend_mask[ent_rd[i]] = 1'b1;
            end
        end
        pend_mask[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rf_we      <= 1'b0;
            rf_wreg    <= '0;
            rf_wdata   <= '0;
            starve_cnt <= '0;
        end else begin
            if (grant_a) begin
                rf_we    <= (a_rd != '0);
                rf_wreg  <= a_rd;
                rf_wdata <= a_data;
            end else if (grant_b) begin
                rf_we    <= (head.rd != '0);
                rf_wreg  <= head.rd;
                rf_wdata <= head.data;
            end else begin
                rf_we <= 1'b0;
            end

            if (grant_b || empty) begin
                starve_cnt <= '0;
            end else if (grant_a && (starve_cnt != CNT_MAX)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based model of the arbitration rules.
module tb_rf_wb_arbiter;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [4:0]  a_rd = '0;
    logic [31:0] a_data = '0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [4:0]  b_rd = '0;
    logic [31:0] b_data = '0;
    logic        rf_we;
    logic [4:0]  rf_wreg;
    logic [31:0] rf_wdata;
    logic [31:0] pend_mask;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.XLEN(32), .NREG(32), .STARVE_LIMIT(LIM)) dut (
        .clk       (clk),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_rd      (a_rd),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_rd      (b_rd),
        .b_data    (b_data),
        .rf_we     (rf_we),
        .rf_wreg   (rf_wreg),
        .rf_wdata  (rf_wdata),
        .pend_mask (pend_mask)
    );

    typedef struct {
        int          rd;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    int          waited;
    int          wlog[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic        e_ardy, e_brdy, e_we;
    logic [31:0] e_pm, e_wdata;
    logic [4:0]  e_wreg;

    // Expected combinational outputs for the current inputs and model state.
    task automatic model_comb();
        e_pm = '0;
        if (!reset) begin
            e_ardy = 1'b0;
            e_brdy = 1'b0;
        end else begin
            e_ardy = !(q.size() > 0 && waited == LIM);
            e_brdy = q.size() < 2;
            foreach (q[i]) if (q[i].rd != 0) e_pm |= 32'h1 << q[i].rd;
        end
    endtask

    // Advance the model across one edge, clock the DUT, and log observed writes.
    task automatic tick();
        bit   ga, gb, push;
        ent_t e;
        model_comb();
        if (!reset) begin
            q.delete();
            waited  = 0;
            e_we    = 1'b0;
            e_wreg  = '0;
            e_wdata = '0;
        end else begin
            ga   = a_valid && e_ardy;
            gb   = !ga && q.size() > 0;
            push = b_valid && e_brdy;
            e_we = 1'b0;
            if (ga) begin
                e_we = (a_rd != 0); e_wreg = a_rd; e_wdata = a_data;
            end else if (gb) begin
                e_we = (q[0].rd != 0); e_wreg = 5'(q[0].rd); e_wdata = q[0].data;
            end
            if (gb || q.size() == 0) waited = 0;
            else if (ga && waited < LIM) waited++;
            if (gb) void'(q.pop_front());
            if (push) begin
                e.rd = int'(b_rd); e.data = b_data; q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        if (rf_we) wlog.push_back(int'(rf_wreg));
    endtask

    task automatic test_reset();
        reset = 1'b0; a_valid = 1'b1; a_rd = 5'd4; a_data = 32'h1111;
        b_valid = 1'b1; b_rd = 5'd6; b_data = 32'h2222;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_cmp++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL reset_a_ready: got %b want 0", a_ready); end
            n_cmp++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL reset_b_ready: got %b want 0", b_ready); end
            n_cmp++; if (pend_mask !== 32'h0) begin n_fail++; $display("FAIL reset_pend_mask: got %h want 0", pend_mask); end
            tick();
            n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
            n_cmp++; if (rf_wreg !== 5'd0 || rf_wdata !== 32'h0) begin
                n_fail++; $display("FAIL reset_rf_regs: got %0d/%h want 0/0", rf_wreg, rf_wdata);
            end
        end
        reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        #1;
        n_cmp++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
            n_fail++; $display("FAIL release_readies: got a=%b b=%b want 1/1", a_ready, b_ready);
        end
        tick();
        n_cmp++; if (rf_we !== 1'b0 || pend_mask !== 32'h0) begin
            n_fail++; $display("FAIL release_no_write: got we=%b mask=%h want 0/0", rf_we, pend_mask);
        end
    endtask

    task automatic test_a_only();
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
        #1;
        n_cmp++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL a_only_ready: got %b want 1", a_ready); end
        tick();
        a_valid = 1'b0;
        n_cmp++; if (rf_we !== 1'b1 || rf_wreg !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL a_only_write: got we=%b rd=%0d data=%h want 1/5/deadbeef", rf_we, rf_wreg, rf_wdata);
        end
        tick();
        n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL a_only_single: got we=%b want 0", rf_we); end
    endtask

    task automatic test_b_only();
        b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h12345678;
        #1;
        n_cmp++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL b_only_ready: got %b want 1", b_ready); end
        tick();
        b_valid = 1'b0;
        #1;
        n_cmp++; if (pend_mask !== 32'h80) begin n_fail++; $display("FAIL b_only_pend: got %h want 00000080", pend_mask); end
        tick();
        n_cmp++; if (rf_we !== 1'b1 || rf_wreg !== 5'd7 || rf_wdata !== 32'h12345678) begin
            n_fail++; $display("FAIL b_only_write: got we=%b rd=%0d data=%h want 1/7/12345678", rf_we, rf_wreg, rf_wdata);
        end
        n_cmp++; if (pend_mask !== 32'h0) begin n_fail++; $display("FAIL b_only_pend_clear: got %h want 0", pend_mask); end
        tick();
        n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL b_only_single: got we=%b want 0", rf_we); end
    endtask

    task automatic test_starvation();
        int   exp_wr[7] = '{3, 4, 5, 6, 7, 9, 8};
        logic exp_ar[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        int   cur = 3;
        logic got_ar;
        wlog.delete();
        a_valid = 1'b1;
        for (int c = 0; c < 7; c++) begin
            a_rd = 5'(cur); a_data = 32'hA000 + 32'(cur);
            b_valid = (c == 0); b_rd = 5'd9; b_data = 32'hB009;
            #1;
            got_ar = a_ready;
            n_cmp++; if (got_ar !== exp_ar[c]) begin
                n_fail++; $display("FAIL starve_a_ready[%0d]: got %b want %b", c, got_ar, exp_ar[c]);
            end
            tick();
            if (got_ar === 1'b1) cur++;
        end
        a_valid = 1'b0; b_valid = 1'b0;
        n_cmp++; if (wlog.size() != 7) begin n_fail++; $display("FAIL starve_write_count: got %0d want 7", wlog.size()); end
        for (int i = 0; i < 7; i++) begin
            if (i < wlog.size()) begin
                n_cmp++; if (wlog[i] != exp_wr[i]) begin
                    n_fail++; $display("FAIL starve_order[%0d]: got rd %0d want %0d", i, wlog[i], exp_wr[i]);
                end
            end
        end
    endtask

    task automatic test_fifo_full();
        int  exp_b[3] = '{10, 11, 12};
        int  got_b[$];
        bit  pushed12 = 0;
        wlog.delete();
        for (int c = 0; c < 20; c++) begin
            a_valid = 1'b1; a_rd = 5'd1; a_data = 32'(c);
            if (c == 0)      begin b_valid = 1'b1; b_rd = 5'd10; end
            else if (c == 1) begin b_valid = 1'b1; b_rd = 5'd11; end
            else             begin b_valid = !pushed12; b_rd = 5'd12; end
            b_data = 32'hF000 + 32'(b_rd);
            #1;
            if (c == 2) begin
                n_cmp++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL full_b_ready: got %b want 0", b_ready); end
                n_cmp++; if (pend_mask !== 32'h00000C00) begin
                    n_fail++; $display("FAIL full_pend: got %h want 00000c00", pend_mask);
                end
            end
            if (c >= 2 && b_valid && b_ready) pushed12 = 1;
            tick();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        foreach (wlog[i]) if (wlog[i] >= 10) got_b.push_back(wlog[i]);
        n_cmp++; if (got_b.size() != 3) begin n_fail++; $display("FAIL full_b_count: got %0d want 3", got_b.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < got_b.size()) begin
                n_cmp++; if (got_b[i] != exp_b[i]) begin
                    n_fail++; $display("FAIL full_order[%0d]: got rd %0d want %0d", i, got_b[i], exp_b[i]);
                end
            end
        end
    endtask

    task automatic test_x0();
        a_valid = 1'b1; a_rd = 5'd0; a_data = 32'h5A5A;
        #1;
        n_cmp++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL x0_a_ready: got %b want 1", a_ready); end
        tick();
        a_valid = 1'b0;
        n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL x0_a_we: got %b want 0", rf_we); end
        b_valid = 1'b1; b_rd = 5'd0; b_data = 32'h6B6B;
        #1;
        n_cmp++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL x0_b_ready: got %b want 1", b_ready); end
        tick();
        b_valid = 1'b0;
        #1;
        n_cmp++; if (pend_mask !== 32'h0) begin n_fail++; $display("FAIL x0_pend: got %h want 0", pend_mask); end
        tick();
        n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL x0_b_we: got %b want 0", rf_we); end
        tick();
        n_cmp++; if (rf_we !== 1'b0 || b_ready !== 1'b1 || pend_mask !== 32'h0) begin
            n_fail++; $display("FAIL x0_drained: got we=%b b_ready=%b mask=%h want 0/1/0", rf_we, b_ready, pend_mask);
        end
    endtask

    task automatic test_reset_mid();
        a_valid = 1'b1; a_rd = 5'd2; a_data = 32'h2;
        b_valid = 1'b1; b_rd = 5'd13; b_data = 32'hD;
        tick();
        b_rd = 5'd14; b_data = 32'hE;
        tick();
        reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        #1;
        n_cmp++; if (pend_mask !== 32'h0 || a_ready !== 1'b0) begin
            n_fail++; $display("FAIL midreset_outputs: got mask=%h a_ready=%b want 0/0", pend_mask, a_ready);
        end
        tick();
        wlog.delete();
        reset = 1'b1;
        #1;
        n_cmp++; if (pend_mask !== 32'h0 || b_ready !== 1'b1) begin
            n_fail++; $display("FAIL midreset_release: got mask=%h b_ready=%b want 0/1", pend_mask, b_ready);
        end
        for (int c = 0; c < 8; c++) tick();
        n_cmp++; if (wlog.size() != 0) begin
            n_fail++; $display("FAIL midreset_discard: got %0d writes want 0", wlog.size());
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            reset   = ($urandom_range(0, 59) != 0);
            a_valid = ($urandom_range(0, 9) < 7);
            a_rd    = 5'($urandom_range(0, 31));
            a_data  = $urandom;
            b_valid = ($urandom_range(0, 9) < 5);
            b_rd    = 5'($urandom_range(0, 31));
            b_data  = $urandom;
            #1;
            model_comb();
            n_cmp++; if (a_ready !== e_ardy) begin n_fail++; $display("FAIL rand_a_ready@%0d: got %b want %b", c, a_ready, e_ardy); end
            n_cmp++; if (b_ready !== e_brdy) begin n_fail++; $display("FAIL rand_b_ready@%0d: got %b want %b", c, b_ready, e_brdy); end
            n_cmp++; if (pend_mask !== e_pm) begin n_fail++; $display("FAIL rand_pend@%0d: got %h want %h", c, pend_mask, e_pm); end
            tick();
            n_cmp++; if (rf_we !== e_we) begin n_fail++; $display("FAIL rand_we@%0d: got %b want %b", c, rf_we, e_we); end
            if (e_we) begin
                n_cmp++; if (rf_wreg !== e_wreg || rf_wdata !== e_wdata) begin
                    n_fail++; $display("FAIL rand_write@%0d: got %0d/%h want %0d/%h", c, rf_wreg, rf_wdata, e_wreg, e_wdata);
                end
            end
        end
        reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    endtask

    initial begin
        waited = 0;
        test_reset();
        test_a_only();
        test_b_only();
        test_starvation();
        test_fifo_full();
        test_x0();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
